// File: rtl/vga_sync_timer.sv
// vga_sync_timer: horizontal + vertical VGA timing generator.
// Timing requests arrive on runtime inputs. They are copied into shadow registers
// only when a frame wraps, so a frame is never torn by a mid-frame change.
// All outputs are registered and decoded from the next-state counters and the
// next-state shadow. This keeps them aligned with xposition/yposition.

module vga_sync_timer #(
  parameter int XW        = 10,
  parameter int YW        = 10,
  parameter bit HPOL      = 1'b0,
  parameter bit VPOL      = 1'b0,
  parameter int TICK_MODE = 0,
  parameter int H_ACT     = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACT     = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          PixelTick,
  input  logic [XW-1:0] HAct,
  input  logic [XW-1:0] HFP,
  input  logic [XW-1:0] HSync,
  input  logic [XW-1:0] HBP,
  input  logic [YW-1:0] VAct,
  input  logic [YW-1:0] VFP,
  input  logic [YW-1:0] VSync,
  input  logic [YW-1:0] VBP,
  output logic          hsync,
  output logic          vsync,
  output logic          VideoOn,
  output logic [XW-1:0] xposition,
  output logic [YW-1:0] yposition,
  output logic          LineEnd,
  output logic          FrameEnd,
  output logic          CfgError
);

  localparam int HTW = XW + 2;
  localparam int VTW = YW + 2;
  localparam logic [HTW-1:0] HMAX = HTW'(1) << XW;
  localparam logic [VTW-1:0] VMAX = VTW'(1) << YW;

  logic tick;

  // Shadow copy of the timing that the current frame is running with
  logic [XW-1:0] hActS, hFpS, hSyncS, hBpS;
  logic [YW-1:0] vActS, vFpS, vSyncS, vBpS;

  // Next-state shadow values, which the output decode uses
  logic [XW-1:0] nHAct, nHFp, nHSync;
  logic [YW-1:0] nVAct, nVFp, nVSync;

  logic [HTW-1:0] hTot, reqHTot, hSyncStart, hSyncStop, xNextW;
  logic [VTW-1:0] vTot, reqVTot, vSyncStart, vSyncStop, yNextW;
  logic [XW-1:0]  xNext;
  logic [YW-1:0]  yNext;
  logic xAtEnd, yAtEnd, lineWrap, frameWrap, reqOk, loadCfg, hActive, vActive;

  generate
    if (TICK_MODE == 1) begin : g_async_tick
      logic syncA, syncB, syncPrev;

      // Bring the asynchronous pixel clock into the clock domain and remember the last level for edge detection
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          syncA    <= 1'b1;
          syncB    <= 1'b1;
          syncPrev <= 1'b1;
        end else begin
          syncA    <= PixelTick;
          syncB    <= syncA;
          syncPrev <= syncB;
        end
      end

      assign tick = syncPrev & ~syncB;
    end else begin : g_sync_tick
      assign tick = PixelTick;
    end
  endgenerate

  // The totals are one width class wider than the counters, so a bad request cannot wrap around and look legal
  assign hTot    = HTW'(hActS) + HTW'(hFpS) + HTW'(hSyncS) + HTW'(hBpS);
  assign vTot    = VTW'(vActS) + VTW'(vFpS) + VTW'(vSyncS) + VTW'(vBpS);
  assign reqHTot = HTW'(HAct) + HTW'(HFP) + HTW'(HSync) + HTW'(HBP);
  assign reqVTot = VTW'(VAct) + VTW'(VFP) + VTW'(VSync) + VTW'(VBP);
  assign reqOk   = (reqHTot >= HTW'(2)) && (reqHTot <= HMAX) &&
                   (reqVTot >= VTW'(2)) && (reqVTot <= VMAX);

  assign xAtEnd    = (HTW'(xposition) == hTot - HTW'(1));
  assign yAtEnd    = (VTW'(yposition) == vTot - VTW'(1));
  assign lineWrap  = tick & xAtEnd;
  assign frameWrap = lineWrap & yAtEnd;
  assign loadCfg   = frameWrap & reqOk;

  assign xNext = lineWrap ? '0 : (tick ? xposition + XW'(1) : xposition);
  assign yNext = lineWrap ? (yAtEnd ? '0 : yposition + YW'(1)) : yposition;

  assign nHAct  = loadCfg ? HAct  : hActS;
  assign nHFp   = loadCfg ? HFP   : hFpS;
  assign nHSync = loadCfg ? HSync : hSyncS;
  assign nVAct  = loadCfg ? VAct  : vActS;
  assign nVFp   = loadCfg ? VFP   : vFpS;
  assign nVSync = loadCfg ? VSync : vSyncS;

  // A zero-length sync gives start == stop, so the window is empty and sync never asserts
  assign xNextW     = HTW'(xNext);
  assign yNextW     = VTW'(yNext);
  assign hSyncStart = HTW'(nHAct) + HTW'(nHFp);
  assign hSyncStop  = hSyncStart + HTW'(nHSync);
  assign vSyncStart = VTW'(nVAct) + VTW'(nVFp);
  assign vSyncStop  = vSyncStart + VTW'(nVSync);
  assign hActive    = (xNextW >= hSyncStart) && (xNextW < hSyncStop);
  assign vActive    = (yNextW >= vSyncStart) && (yNextW < vSyncStop);

  // Advance the counters, swap in new timing at frame wraps and register every decoded output
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xposition <= '0;
      yposition <= '0;
      hActS     <= XW'(H_ACT);
      hFpS      <= XW'(H_FP);
      hSyncS    <= XW'(H_SYNC);
      hBpS      <= XW'(H_BP);
      vActS     <= YW'(V_ACT);
      vFpS      <= YW'(V_FP);
      vSyncS    <= YW'(V_SYNC);
      vBpS      <= YW'(V_BP);
      hsync     <= ~HPOL;
      vsync     <= ~VPOL;
      VideoOn   <= 1'b0;
      LineEnd   <= 1'b0;
      FrameEnd  <= 1'b0;
      CfgError  <= 1'b0;
    end else begin
      xposition <= xNext;
      yposition <= yNext;
      if (loadCfg) begin
        hActS  <= HAct;
        hFpS   <= HFP;
        hSyncS <= HSync;
        hBpS   <= HBP;
        vActS  <= VAct;
        vFpS   <= VFP;
        vSyncS <= VSync;
        vBpS   <= VBP;
      end
      hsync    <= hActive ? HPOL : ~HPOL;
      vsync    <= vActive ? VPOL : ~VPOL;
      VideoOn  <= (xNext < nHAct) && (yNext < nVAct);
      LineEnd  <= lineWrap;
      FrameEnd <= frameWrap;
      CfgError <= CfgError | (frameWrap & ~reqOk);
    end
  end

endmodule
